// File: rtl/adma_dm_pkg.sv
// Shared definitions for the ADMA data-mover transaction generators:
// AXI burst encodings, the 4KB page size, FSM states and width helpers.
package adma_dm_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  localparam int BOUNDARY_4K = 4096;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  // Width needed to count every beat left in one 4KB page, including a full page.
  function automatic int cnt_width(input int beat_bytes);
    return $clog2(BOUNDARY_4K / beat_bytes) + 1;
  endfunction

  function automatic int chn_width(input int chn_num);
    return (chn_num > 1) ? $clog2(chn_num) : 1;
  endfunction

endpackage

// File: rtl/adma_dm_burst_calc.sv
// Sizes the next AXI INCR burst from the current address and remaining beats,
// and produces the address that follows it. Shared by read and write generators.
module adma_dm_burst_calc
  import adma_dm_pkg::*;
#(
  parameter int SRC_ADDR_W  = 32,
  parameter int REQ_LEN_W   = 16,
  parameter int ATX_MAX_LEN = 256,
  parameter int BEAT_BYTES  = 32,
  parameter int CNT_W       = cnt_width(BEAT_BYTES)
) (
  input  logic [SRC_ADDR_W-1:0] cur_addr,
  input  logic [REQ_LEN_W-1:0]  rem,
  output logic [CNT_W-1:0]      beats,
  output logic                  last,
  output logic [SRC_ADDR_W-1:0] next_addr
);

  localparam int BB_LOG = $clog2(BEAT_BYTES);
  localparam int WW     = (REQ_LEN_W > 32) ? REQ_LEN_W : 32;

  logic [12:0]      span;
  logic [CNT_W-1:0] to4k;
  logic [WW-1:0]    rem_w;
  logic [WW-1:0]    max_w;
  logic [WW-1:0]    to4k_w;
  logic [WW-1:0]    min_a;
  logic [WW-1:0]    min_b;

  // The address is beat aligned, so the bytes left in the page divide exactly.
  always_comb begin
    span   = 13'(BOUNDARY_4K) - {1'b0, cur_addr[11:0]};
    to4k   = CNT_W'(span >> BB_LOG);
    rem_w  = WW'(rem);
    max_w  = WW'(ATX_MAX_LEN);
    to4k_w = WW'(to4k);
    min_a  = (rem_w < max_w) ? rem_w : max_w;
    min_b  = (min_a < to4k_w) ? min_a : to4k_w;
    beats  = CNT_W'(min_b);
    last   = (rem_w == min_b);
    next_addr = cur_addr + (SRC_ADDR_W'(beats) << BB_LOG);
  end

endmodule

// File: rtl/adma_dm_rd_atx_gen.sv
// Read transaction generator: takes one read request at a time and issues it to
// the read host as AXI INCR bursts bounded by the max burst length and 4KB pages.
module adma_dm_rd_atx_gen
  import adma_dm_pkg::*;
#(
  parameter int DMA_CHN_NUM    = 4,
  parameter int SRC_ADDR_W     = 32,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_SRC_DATA_W = 256,
  parameter int ATX_MAX_LEN    = 256,
  parameter int REQ_LEN_W      = 16,
  parameter int DMA_CHN_NUM_W  = chn_width(DMA_CHN_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] req_chn_id,
  input  logic [SRC_ADDR_W-1:0]    req_addr,
  input  logic [REQ_LEN_W-1:0]     req_beats,
  input  logic                     req_vld,
  output logic                     req_rdy,
  output logic                     req_done,
  output logic [DMA_CHN_NUM_W-1:0] req_done_chn,
  output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  output logic [MST_ID_W-1:0]      atx_arid,
  output logic [SRC_ADDR_W-1:0]    atx_araddr,
  output logic [ATX_LEN_W-1:0]     atx_arlen,
  output logic [1:0]               atx_arburst,
  output logic                     atx_last,
  output logic                     atx_vld,
  input  logic                     atx_rdy
);

  localparam int BEAT_BYTES = ATX_SRC_DATA_W / 8;
  localparam int BB_LOG     = $clog2(BEAT_BYTES);
  localparam int CNT_W      = cnt_width(BEAT_BYTES);
  localparam logic [SRC_ADDR_W-1:0] ALIGN_MASK = ~SRC_ADDR_W'((1 << BB_LOG) - 1);

  logic [0:0]               state;
  logic                     rdy_q;
  logic                     done_q;
  logic [DMA_CHN_NUM_W-1:0] done_chn_q;
  logic [DMA_CHN_NUM_W-1:0] chn;
  logic [SRC_ADDR_W-1:0]    cur_addr;
  logic [REQ_LEN_W-1:0]     rem;

  logic [CNT_W-1:0]         beats;
  logic                     last;
  logic [SRC_ADDR_W-1:0]    next_addr;

  adma_dm_burst_calc #(
    .SRC_ADDR_W  (SRC_ADDR_W),
    .REQ_LEN_W   (REQ_LEN_W),
    .ATX_MAX_LEN (ATX_MAX_LEN),
    .BEAT_BYTES  (BEAT_BYTES),
    .CNT_W       (CNT_W)
  ) u_burst_calc (
    .cur_addr  (cur_addr),
    .rem       (rem),
    .beats     (beats),
    .last      (last),
    .next_addr (next_addr)
  );

  // req_rdy is registered, so it comes up one cycle after reset is released
  // and one cycle after the final burst handshake, never overlapping a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      done_chn_q <= '0;
      chn        <= '0;
      cur_addr   <= '0;
      rem        <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        rdy_q <= 1'b1;
        if (req_vld && rdy_q) begin
          chn      <= req_chn_id;
          cur_addr <= req_addr & ALIGN_MASK;
          rem      <= req_beats;
          if (req_beats == '0) begin
            done_q     <= 1'b1;
            done_chn_q <= req_chn_id;
          end else begin
            state <= SPLIT;
            rdy_q <= 1'b0;
          end
        end
      end else if (atx_rdy) begin
        cur_addr <= next_addr;
        rem      <= rem - REQ_LEN_W'(beats);
        if (last) begin
          done_q     <= 1'b1;
          done_chn_q <= chn;
          state      <= IDLE;
          rdy_q      <= 1'b1;
        end
      end
    end
  end

  // Burst fields derive from registered state, so they hold while stalled.
  always_comb begin
    atx_vld      = (state == SPLIT);
    atx_araddr   = atx_vld ? cur_addr : '0;
    atx_arlen    = atx_vld ? ATX_LEN_W'(beats - CNT_W'(1)) : '0;
    atx_last     = atx_vld & last;
    atx_chn_id   = chn;
    atx_arid     = MST_ID_W'(chn);
    atx_arburst  = BURST_INCR;
    req_rdy      = rdy_q;
    req_done     = done_q;
    req_done_chn = done_chn_q;
  end

endmodule

// File: tb/tb_adma_dm_rd_atx_gen.sv
// Bench for adma_dm_rd_atx_gen: a burst-list model checked every cycle against
// two instances (default max length 256 and max length 16).
module tb_adma_dm_rd_atx_gen;

  typedef struct {
    int          inst;
    logic [1:0]  chn;
    logic [31:0] addr;
    int          len;
    bit          last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_chn_id   [2];
  logic [31:0] req_addr     [2];
  logic [15:0] req_beats    [2];
  logic        req_vld      [2];
  logic        req_rdy      [2];
  logic        req_done     [2];
  logic [1:0]  req_done_chn [2];
  logic [1:0]  atx_chn_id   [2];
  logic [4:0]  atx_arid     [2];
  logic [31:0] atx_araddr   [2];
  logic [7:0]  atx_arlen    [2];
  logic [1:0]  atx_arburst  [2];
  logic        atx_last     [2];
  logic        atx_vld      [2];
  logic        atx_rdy      [2];

  int          checks = 0;
  int          failures = 0;
  burst_t      exp_q[$];
  burst_t      plan_q[$];
  bit          done_pending [2];
  logic [1:0]  done_exp_chn [2];
  bit          rand_rdy     [2];

  always #5 clk = ~clk;

  adma_dm_rd_atx_gen dut0 (
    .clk(clk), .rst(rst),
    .req_chn_id(req_chn_id[0]), .req_addr(req_addr[0]), .req_beats(req_beats[0]),
    .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_done(req_done[0]),
    .req_done_chn(req_done_chn[0]), .atx_chn_id(atx_chn_id[0]), .atx_arid(atx_arid[0]),
    .atx_araddr(atx_araddr[0]), .atx_arlen(atx_arlen[0]), .atx_arburst(atx_arburst[0]),
    .atx_last(atx_last[0]), .atx_vld(atx_vld[0]), .atx_rdy(atx_rdy[0])
  );

  adma_dm_rd_atx_gen #(.ATX_MAX_LEN(16)) dut1 (
    .clk(clk), .rst(rst),
    .req_chn_id(req_chn_id[1]), .req_addr(req_addr[1]), .req_beats(req_beats[1]),
    .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_done(req_done[1]),
    .req_done_chn(req_done_chn[1]), .atx_chn_id(atx_chn_id[1]), .atx_arid(atx_arid[1]),
    .atx_araddr(atx_araddr[1]), .atx_arlen(atx_arlen[1]), .atx_arburst(atx_arburst[1]),
    .atx_last(atx_last[1]), .atx_vld(atx_vld[1]), .atx_rdy(atx_rdy[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference split: walk the request page by page with 32-byte beats.
  function automatic void model_split(input int inst, input logic [1:0] chn,
                                      input logic [31:0] addr, input int beats);
    int          max_len;
    int          rem;
    int          to4k;
    int          b;
    logic [31:0] a;
    max_len = (inst == 0) ? 256 : 16;
    a = addr & 32'hFFFF_FFE0;
    rem = beats;
    plan_q.delete();
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 32;
      b = rem;
      if (b > max_len) b = max_len;
      if (b > to4k) b = to4k;
      plan_q.push_back('{inst, chn, a, b - 1, rem == b});
      a = a + 32'(b * 32);
      rem = rem - b;
    end
  endfunction

  // One compare process: every cycle the DUT outputs must match the model queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput("req_done", 64'(req_done[k]), 64'(done_pending[k]));
      if (done_pending[k])
        checkOutput("req_done_chn", 64'(req_done_chn[k]), 64'(done_exp_chn[k]));
      done_pending[k] = 1'b0;
      checkOutput("atx_arburst", 64'(atx_arburst[k]), 64'd1);
      if (atx_vld[k]) begin
        if (exp_q.size() == 0 || exp_q[0].inst != k) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_burst inst=%0d actual araddr=0x%0h arlen=%0d required no burst",
                   k, atx_araddr[k], atx_arlen[k]);
        end else begin
          checkOutput("atx_araddr", 64'(atx_araddr[k]), 64'(exp_q[0].addr));
          checkOutput("atx_arlen", 64'(atx_arlen[k]), 64'(exp_q[0].len));
          checkOutput("atx_last", 64'(atx_last[k]), 64'(exp_q[0].last));
          checkOutput("atx_chn_id", 64'(atx_chn_id[k]), 64'(exp_q[0].chn));
          checkOutput("atx_arid", 64'(atx_arid[k]), 64'(exp_q[0].chn));
          checkOutput("req_rdy_busy", 64'(req_rdy[k]), 64'd0);
          if (atx_rdy[k]) begin
            if (exp_q[0].last) begin
              done_pending[k] = 1'b1;
              done_exp_chn[k] = exp_q[0].chn;
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        if (rand_rdy[k]) atx_rdy[k] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input int k, input logic [1:0] chn,
                               input logic [31:0] addr, input int beats);
    bit acc;
    acc = 1'b0;
    req_chn_id[k] = chn;
    req_addr[k]   = addr;
    req_beats[k]  = 16'(beats);
    req_vld[k]    = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = req_rdy[k];
    end
    if (acc) @(posedge clk);
    #1;
    req_vld[k] = 1'b0;
    checkOutput("req_accept", 64'(acc), 64'd1);
    if (acc) begin
      if (beats == 0) begin
        done_pending[k] = 1'b1;
        done_exp_chn[k] = chn;
      end else begin
        model_split(k, chn, addr, beats);
        foreach (plan_q[i]) exp_q.push_back(plan_q[i]);
      end
    end
  endtask

  task automatic wait_idle(input int k);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(posedge clk);
      #2;
      idle = (exp_q.size() == 0) && !done_pending[k] && req_rdy[k];
    end
    checkOutput("idle_timeout", 64'(idle), 64'd1);
  endtask

  initial begin : main
    logic [31:0] addr;
    int          beats;
    int          k;
    int          mode;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_chn_id[i] = '0; req_addr[i] = '0; req_beats[i] = '0;
      req_vld[i] = 1'b0; atx_rdy[i] = 1'b0; rand_rdy[i] = 1'b0;
      done_pending[i] = 1'b0; done_exp_chn[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_req_rdy", 64'(req_rdy[i]), 64'd0);
      checkOutput("rst_atx_vld", 64'(atx_vld[i]), 64'd0);
      checkOutput("rst_araddr", 64'(atx_araddr[i]), 64'd0);
      checkOutput("rst_arlen", 64'(atx_arlen[i]), 64'd0);
      checkOutput("rst_arid", 64'(atx_arid[i]), 64'd0);
      checkOutput("rst_last", 64'(atx_last[i]), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // Single burst with literal expectations.
    atx_rdy[0] = 1'b1;
    applyStimulus(0, 2'd1, 32'h1000, 16);
    @(negedge clk);
    checkOutput("t1_vld", 64'(atx_vld[0]), 64'd1);
    checkOutput("t1_araddr", 64'(atx_araddr[0]), 64'h1000);
    checkOutput("t1_arlen", 64'(atx_arlen[0]), 64'd15);
    checkOutput("t1_arid", 64'(atx_arid[0]), 64'd1);
    checkOutput("t1_last", 64'(atx_last[0]), 64'd1);
    @(negedge clk);
    checkOutput("t1_done", 64'(req_done[0]), 64'd1);
    checkOutput("t1_done_chn", 64'(req_done_chn[0]), 64'd1);
    wait_idle(0);

    // 300 beats from 0: 128+128+44, issued back to back.
    model_split(0, 2'd0, 32'h0, 300);
    checkOutput("m2_count", 64'(plan_q.size()), 64'd3);
    checkOutput("m2_b2_addr", 64'(plan_q[1].addr), 64'h1000);
    checkOutput("m2_b3_addr", 64'(plan_q[2].addr), 64'h2000);
    checkOutput("m2_b3_len", 64'(plan_q[2].len), 64'd43);
    checkOutput("m2_b1_len", 64'(plan_q[0].len), 64'd127);
    applyStimulus(0, 2'd0, 32'h0, 300);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t2_vld", 64'(atx_vld[0]), 64'(i < 3));
      checkOutput("t2_done", 64'(req_done[0]), 64'(i == 3));
    end
    wait_idle(0);

    // Request straddling a 4KB page.
    model_split(0, 2'd3, 32'h0FE0, 4);
    checkOutput("m3_count", 64'(plan_q.size()), 64'd2);
    checkOutput("m3_b1_len", 64'(plan_q[0].len), 64'd0);
    checkOutput("m3_b2_addr", 64'(plan_q[1].addr), 64'h1000);
    checkOutput("m3_b2_len", 64'(plan_q[1].len), 64'd2);
    applyStimulus(0, 2'd3, 32'h0FE0, 4);
    wait_idle(0);

    // Max burst length 16 instance.
    model_split(1, 2'd2, 32'h0, 40);
    checkOutput("m4_count", 64'(plan_q.size()), 64'd3);
    checkOutput("m4_b2_addr", 64'(plan_q[1].addr), 64'h200);
    checkOutput("m4_b3_addr", 64'(plan_q[2].addr), 64'h400);
    checkOutput("m4_b3_len", 64'(plan_q[2].len), 64'd7);
    atx_rdy[1] = 1'b1;
    applyStimulus(1, 2'd2, 32'h0, 40);
    wait_idle(1);

    // Backpressure after the first burst.
    applyStimulus(0, 2'd1, 32'h0, 300);
    @(posedge clk);
    #1 atx_rdy[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5_vld", 64'(atx_vld[0]), 64'd1);
      checkOutput("t5_araddr", 64'(atx_araddr[0]), 64'h1000);
      checkOutput("t5_arlen", 64'(atx_arlen[0]), 64'd127);
      checkOutput("t5_req_rdy", 64'(req_rdy[0]), 64'd0);
      checkOutput("t5_done", 64'(req_done[0]), 64'd0);
    end
    @(posedge clk);
    #1 atx_rdy[0] = 1'b1;
    wait_idle(0);

    // Zero-length request.
    applyStimulus(0, 2'd2, 32'h40, 0);
    @(negedge clk);
    checkOutput("t6_done", 64'(req_done[0]), 64'd1);
    checkOutput("t6_done_chn", 64'(req_done_chn[0]), 64'd2);
    checkOutput("t6_vld", 64'(atx_vld[0]), 64'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_vld_after", 64'(atx_vld[0]), 64'd0);
      checkOutput("t6_req_rdy", 64'(req_rdy[0]), 64'd1);
    end
    wait_idle(0);

    // Reset while the second burst is pending.
    atx_rdy[0] = 1'b0;
    applyStimulus(0, 2'd3, 32'h0, 300);
    atx_rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    atx_rdy[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_second", 64'(atx_araddr[0]), 64'h1000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    done_pending[0] = 1'b0;
    done_pending[1] = 1'b0;
    @(negedge clk);
    checkOutput("t7_vld", 64'(atx_vld[0]), 64'd0);
    checkOutput("t7_req_rdy0", 64'(req_rdy[0]), 64'd0);
    checkOutput("t7_done0", 64'(req_done[0]), 64'd0);
    @(negedge clk);
    checkOutput("t7_req_rdy1", 64'(req_rdy[0]), 64'd1);
    checkOutput("t7_done1", 64'(req_done[0]), 64'd0);
    wait_idle(0);

    // Randomized requests with random read-host backpressure.
    rand_rdy[0] = 1'b1;
    rand_rdy[1] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      k = $urandom_range(0, 1);
      mode = $urandom_range(0, 3);
      case (mode)
        0: addr = $urandom;
        1: addr = ($urandom & 32'hFFFF_F000) | 32'(12'hF00 + 12'($urandom_range(0, 255)));
        2: addr = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
        default: addr = 32'($urandom_range(0, 8191));
      endcase
      beats = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
      applyStimulus(k, 2'($urandom_range(0, 3)), addr, beats);
      wait_idle(k);
    end
    rand_rdy[0] = 1'b0;
    rand_rdy[1] = 1'b0;

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
